// File: rtl/fx_pkg.sv
// Shared 100BASE-FX definitions: 4B/5B control code groups and the TX state encoding.
// The receive-path delimiter detection uses the same constants.
package fx_pkg;

    localparam logic [4:0] CG_IDLE = 5'b11111;
    localparam logic [4:0] CG_J    = 5'b11000;
    localparam logic [4:0] CG_K    = 5'b10001;
    localparam logic [4:0] CG_T    = 5'b01101;
    localparam logic [4:0] CG_R    = 5'b00111;
    localparam logic [4:0] CG_H    = 5'b00100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SSD_K,
        ST_DATA,
        ST_ESD_R
    } tx_state_t;

endpackage

// File: rtl/enc4b5b.sv
// Combinational 4B/5B data encoder; the exact inverse of the receive decoder table.
module enc4b5b (
    input  logic [3:0] nib,
    output logic [4:0] code
);

    always_comb begin
        code = 5'b11110;
        case (nib)
            4'h0: code = 5'b11110;
            4'h1: code = 5'b01001;
            4'h2: code = 5'b10100;
            4'h3: code = 5'b10101;
            4'h4: code = 5'b01010;
            4'h5: code = 5'b01011;
            4'h6: code = 5'b01110;
            4'h7: code = 5'b01111;
            4'h8: code = 5'b10010;
            4'h9: code = 5'b10011;
            4'hA: code = 5'b10110;
            4'hB: code = 5'b10111;
            4'hC: code = 5'b11010;
            4'hD: code = 5'b11011;
            4'hE: code = 5'b11100;
            4'hF: code = 5'b11101;
            default: code = 5'b11110;
        endcase
    end

endmodule

// File: rtl/fx_tx_enc4b5b.sv
// 100BASE-FX transmit front end: MII nibbles -> J/K, 4B/5B data, T/R, IDLE fill,
// serialised MSB-first at the 125 MHz bit clock with optional NRZI.
module fx_tx_enc4b5b
    import fx_pkg::*;
#(
    parameter bit NRZI_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_en,
    input  logic       i_tx_er,
    input  logic [3:0] i_txd,
    output logic       o_nib_req,
    output logic [4:0] o_tx_code,
    output logic       o_tx_bit,
    output logic       o_busy
);

    tx_state_t  state, nxt_state;
    logic [2:0] bcnt;
    logic [4:0] sh;
    logic [4:0] nxt_code;
    logic [4:0] data_code;
    logic       cur_bit;

    enc4b5b u_enc (
        .nib  (i_txd),
        .code (data_code)
    );

    assign o_nib_req = (bcnt == 3'd4);
    assign o_busy    = (state != ST_IDLE);
    // sh is a copy of o_tx_code shifted left once per bit, so its MSB is o_tx_code[4-bcnt]
    assign cur_bit   = sh[4];

    always_comb begin
        nxt_state = state;
        nxt_code  = CG_IDLE;
        case (state)
            ST_IDLE: begin
                if (i_tx_en) begin
                    nxt_code  = CG_J;
                    nxt_state = ST_SSD_K;
                end
            end
            ST_SSD_K: begin
                if (i_tx_en) begin
                    nxt_code  = CG_K;
                    nxt_state = ST_DATA;
                end else begin
                    nxt_code  = CG_T;
                    nxt_state = ST_ESD_R;
                end
            end
            ST_DATA: begin
                if (!i_tx_en) begin
                    nxt_code  = CG_T;
                    nxt_state = ST_ESD_R;
                end else if (i_tx_er) begin
                    nxt_code  = CG_H;
                end else begin
                    nxt_code  = data_code;
                end
            end
            ST_ESD_R: begin
                nxt_code  = CG_R;
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_code  = CG_IDLE;
                nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            bcnt      <= 3'd0;
            o_tx_code <= CG_IDLE;
            sh        <= CG_IDLE;
            o_tx_bit  <= 1'b0;
        end else begin
            bcnt     <= o_nib_req ? 3'd0 : bcnt + 3'd1;
            o_tx_bit <= NRZI_EN ? (o_tx_bit ^ cur_bit) : cur_bit;
            if (o_nib_req) begin
                state     <= nxt_state;
                o_tx_code <= nxt_code;
                sh        <= nxt_code;
            end else begin
                sh <= {sh[3:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_fx_tx_enc4b5b.sv
// Directed bench for fx_tx_enc4b5b: an NRZI instance and an NRZ instance share the same inputs.
module tb_fx_tx_enc4b5b;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en, tx_er;
    logic [3:0] txd;
    logic       nib_req1, nib_req0;
    logic [4:0] code1, code0;
    logic       bit1, bit0;
    logic       busy1, busy0;
    int         vecs = 0;
    int         errs = 0;

    always #4 clk = ~clk;

    fx_tx_enc4b5b #(.NRZI_EN(1'b1)) u_nrzi (
        .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en), .i_tx_er(tx_er), .i_txd(txd),
        .o_nib_req(nib_req1), .o_tx_code(code1), .o_tx_bit(bit1), .o_busy(busy1)
    );

    fx_tx_enc4b5b #(.NRZI_EN(1'b0)) u_nrz (
        .i_clk(clk), .i_rst(rst), .i_tx_en(tx_en), .i_tx_er(tx_er), .i_txd(txd),
        .o_nib_req(nib_req0), .o_tx_code(code0), .o_tx_bit(bit0), .o_busy(busy0)
    );

    // Waits for the nibble-request cycle, drives one nibble, returns the group loaded at that edge.
    task automatic slot(input logic en, input logic er, input logic [3:0] d, output logic [4:0] code);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!nib_req1 && n < 8);
        if (!nib_req1) begin
            vecs++;
            errs++;
            $display("FAIL slot_timeout nib_req got 0 want 1");
        end
        tx_en = en;
        tx_er = er;
        txd   = d;
        @(posedge clk);
        #1;
        code = code1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_en = 1'b0; tx_er = 1'b0; txd = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vecs++;
        if (code1 !== 5'b11111 || code0 !== 5'b11111) begin
            errs++; $display("FAIL reset_code got %b/%b want 11111", code1, code0);
        end
        vecs++;
        if (bit1 !== 1'b0 || bit0 !== 1'b0) begin
            errs++; $display("FAIL reset_bit got %b/%b want 0", bit1, bit0);
        end
        vecs++;
        if (busy1 !== 1'b0 || nib_req1 !== 1'b0) begin
            errs++; $display("FAIL reset_busy_req got busy=%b req=%b want 0/0", busy1, nib_req1);
        end
        rst = 1'b0;
    endtask

    // Continues from the first post-reset cycle (cycle 0).
    task automatic test_idle();
        logic prev;
        prev = bit1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            vecs++;
            if (nib_req1 !== ((i % 5) == 4)) begin
                errs++; $display("FAIL idle_req[%0d] got %b want %b", i, nib_req1, (i % 5) == 4);
            end
            vecs++;
            if (code1 !== 5'b11111 || busy1 !== 1'b0) begin
                errs++; $display("FAIL idle_code[%0d] got %b busy=%b want 11111 busy=0", i, code1, busy1);
            end
            vecs++;
            if (bit1 !== ~prev) begin
                errs++; $display("FAIL idle_nrzi[%0d] got %b want %b", i, bit1, ~prev);
            end
            prev = bit1;
        end
        vecs++;
        if (bit0 !== 1'b1) begin
            errs++; $display("FAIL idle_nrz got %b want 1", bit0);
        end
    endtask

    task automatic test_frame(input int er_idx, input string tag);
        logic [3:0] nibs [10] = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'hA, 4'h0, 4'h0, 4'h0};
        logic [4:0] exp  [10] = '{5'b11000, 5'b10001, 5'b01011, 5'b11011, 5'b01001,
                                  5'b10100, 5'b10110, 5'b01101, 5'b00111, 5'b11111};
        logic [4:0] got;
        if (er_idx >= 0) exp[er_idx] = 5'b00100;
        for (int i = 0; i < 10; i++) begin
            slot(i < 7, i == er_idx, nibs[i], got);
            vecs++;
            if (got !== exp[i] || code0 !== exp[i]) begin
                errs++; $display("FAIL %s[%0d] code got %b/%b want %b", tag, i, got, code0, exp[i]);
            end
            if (i <= 7) begin
                vecs++;
                if (busy1 !== 1'b1) begin
                    errs++; $display("FAIL %s_busy[%0d] got %b want 1", tag, i, busy1);
                end
            end
        end
        vecs++;
        if (busy1 !== 1'b0) begin
            errs++; $display("FAIL %s_busy_end got %b want 0", tag, busy1);
        end
    endtask

    // tx_er on the J slot and tx_en during R are both ignored.
    task automatic test_abort();
        logic [4:0] got;
        slot(1'b1, 1'b1, 4'h3, got);
        vecs++;
        if (got !== 5'b11000) begin errs++; $display("FAIL abort_j got %b want 11000", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b01101) begin errs++; $display("FAIL abort_t got %b want 01101", got); end
        slot(1'b1, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b00111) begin errs++; $display("FAIL abort_r got %b want 00111", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b11111 || busy1 !== 1'b0) begin
            errs++; $display("FAIL abort_idle got %b busy=%b want 11111 busy=0", got, busy1);
        end
    endtask

    task automatic test_serial();
        logic [4:0] got;
        logic       nrz_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       prev;
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b11110) begin errs++; $display("FAIL serial_code got %b want 11110", got); end
        @(negedge clk);
        prev = bit1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vecs++;
            if (bit0 !== nrz_exp[k]) begin
                errs++; $display("FAIL serial_nrz[%0d] got %b want %b", k, bit0, nrz_exp[k]);
            end
            vecs++;
            if (bit1 !== (prev ^ nrz_exp[k])) begin
                errs++; $display("FAIL serial_nrzi[%0d] got %b want %b", k, bit1, prev ^ nrz_exp[k]);
            end
            prev = prev ^ nrz_exp[k];
        end
        slot(1'b0, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b01101) begin errs++; $display("FAIL serial_t got %b want 01101", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        slot(1'b0, 1'b0, 4'h0, got);
    endtask

    task automatic test_reset_mid();
        logic [4:0] got;
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'h7, got);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; tx_en = 1'b0;
        @(posedge clk);
        #1;
        vecs++;
        if (code1 !== 5'b11111 || bit1 !== 1'b0 || bit0 !== 1'b0) begin
            errs++; $display("FAIL rstmid_out got code=%b bits=%b/%b want 11111 0/0", code1, bit1, bit0);
        end
        vecs++;
        if (busy1 !== 1'b0 || nib_req1 !== 1'b0) begin
            errs++; $display("FAIL rstmid_state got busy=%b req=%b want 0/0", busy1, nib_req1);
        end
        @(negedge clk);
        rst = 1'b0;
        slot(1'b1, 1'b0, 4'h5, got);
        vecs++;
        if (got !== 5'b11000 || busy1 !== 1'b1) begin
            errs++; $display("FAIL rstmid_j got %b busy=%b want 11000 busy=1", got, busy1);
        end
        slot(1'b1, 1'b0, 4'h5, got);
        vecs++;
        if (got !== 5'b10001) begin errs++; $display("FAIL rstmid_k got %b want 10001", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        slot(1'b0, 1'b0, 4'h0, got);
    endtask

    // New frame on the very first IDLE-state sample after R.
    task automatic test_back_to_back();
        logic [4:0] got;
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'h5, got);
        slot(1'b1, 1'b0, 4'hE, got);
        vecs++;
        if (got !== 5'b11100) begin errs++; $display("FAIL b2b_data got %b want 11100", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        slot(1'b0, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b00111) begin errs++; $display("FAIL b2b_r got %b want 00111", got); end
        slot(1'b1, 1'b0, 4'h5, got);
        vecs++;
        if (got !== 5'b11000) begin errs++; $display("FAIL b2b_j got %b want 11000", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        vecs++;
        if (got !== 5'b01101) begin errs++; $display("FAIL b2b_t got %b want 01101", got); end
        slot(1'b0, 1'b0, 4'h0, got);
        slot(1'b0, 1'b0, 4'h0, got);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame(-1, "frame");
        test_frame(4, "frame_er");
        test_abort();
        test_serial();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded, summary not reached");
        $fatal(1);
    end

endmodule
